hamming_rx_ctrl: RTL
====================

// Module: hamming_rx_ctrl
// PURPOSE
//  Sequencer for the serial 15->11 Hamming receive path. Gates the 15-bit serial-in
//  codeword shifter, strobes the decoder capture, parallel-loads the 11-bit output
//  shifter and drains it serially with a valid/ready handshake. Replaces the
//  free-running "isfull" counter with an explicit per-frame state machine.
// PARAMETERS
//  CW_BITS  15  codeword length, serial bits accepted per frame
//  DW_BITS  11  data length, serial bits emitted per frame
//  SYN_W    4   decoder syndrome width
// PORTS
//  clk         in   1       rising-edge clock
//  RST         in   1       synchronous reset, active-high
//  start       in   1       begin a frame; sampled only in IDLE
//  in_valid    in   1       sl_in bit valid this cycle
//  in_ready    out  1       controller accepts a serial input bit
//  syndrome    in   SYN_W   decoder syndrome (combinational from the codeword)
//  rx_shift    out  1       shift enable for the 15-bit input shifter
//  dec_capture out  1       1-cycle strobe: decoder output is valid, latch it
//  tx_load     out  1       1-cycle parallel load of the 11-bit output shifter
//  tx_shift    out  1       shift enable for the output shifter
//  out_valid   out  1       serial output bit valid
//  out_ready   in   1       downstream accepts the output bit
//  out_last    out  1       marks the final (DW_BITS-th) output bit
//  busy        out  1       high in every state except IDLE
//  frame_done  out  1       1-cycle pulse after the last output handshake
//  err_flag    out  1       the current/last frame had a nonzero syndrome
//  err_count   out  16      corrected-frame count (present only with HAM_ERR_CNT_EN)
// BEHAVIOUR
//  - States: IDLE, RECV, DECODE, LOAD, SEND. One bit counter cnt, width clog2(CW_BITS+1).
//  - Reset (RST=1 at a clk edge, any state): state=IDLE, cnt=0, err_flag=0,
//    frame_done=0, err_count=0. All strobes/enables are 0 while in IDLE.
//  - IDLE: start=1 -> RECV next cycle, cnt<=0, err_flag<=0. start is ignored in all other states.
//  - RECV: in_ready=1; rx_shift = in_valid (combinational). Each accept increments cnt.
//    An accept with cnt==CW_BITS-1 -> DECODE. in_valid=0 stalls with no timeout.
//  - DECODE: exactly 1 cycle; dec_capture=1; err_flag <= (syndrome!=0); -> LOAD.
//  - LOAD: exactly 1 cycle; tx_load=1; cnt<=0; -> SEND.
//  - SEND: out_valid=1; tx_shift = out_ready (combinational); out_last = (cnt==DW_BITS-1).
//    Each handshake increments cnt. The handshake with out_last=1 -> IDLE, and
//    frame_done is registered high for exactly the next cycle.
//  - Latency: last input accept at edge N -> dec_capture high in cycle N+1,
//    tx_load in N+2, first out_valid in N+3.
//  - Only one of rx_shift, tx_load, tx_shift is high in any cycle (one-hot use of the shifters).
//  - A start pulse in the same cycle frame_done is high is accepted (state is IDLE then).
//  - RST mid-frame discards any partial frame. Shifter contents are not the
//    controller's concern; the next frame fully reloads them.
// CONFIGURATION
//  - HAM_ERR_CNT_EN defined: err_count increments in DECODE when syndrome!=0 and
//    saturates at 16'hFFFF. It is cleared only by RST.
//  - HAM_ERR_CNT_EN undefined: the err_count port and its logic are absent.
//    err_flag is unaffected either way.
// TESTING
//  1. RST=1 for 2 cycles during SEND -> next cycle busy=0, out_valid=0, err_flag=0, cnt=0.
//  2. start; 15 back-to-back in_valid bits with clean codeword (syndrome=0) ->
//     dec_capture at cycle 16, tx_load at 17, 11 out bits with out_ready=1,
//     out_last on the 11th, frame_done 1 cycle later, err_flag=0.
//  3. Same frame with bit 5 flipped (syndrome=4'h5) -> err_flag=1 after DECODE.
//     With HAM_ERR_CNT_EN, err_count goes 0->1.
//  4. in_valid toggling 1,0,1,0 -> exactly 15 rx_shift pulses, DECODE only after the 15th.
//     out_ready low for 3 cycles mid-SEND -> out_valid held, cnt frozen, no bit lost.
//  5. start held high throughout 2 frames -> frames run back-to-back.
//     No start effect while busy=1; new RECV begins the cycle after frame_done.
//  6. HAM_ERR_CNT_EN, err_count preloaded near 16'hFFFF via 65535 errored frames
//     (or forced) -> a further errored frame leaves err_count=16'hFFFF.

Source files
------------

// File: rtl/hamming_rx_ctrl.sv
// Per-frame sequencer for the serial 15->11 Hamming receive path.
// Define HAM_ERR_CNT_EN to add the saturating err_count output.
module hamming_rx_ctrl #(
  parameter int CW_BITS = 15,
  parameter int DW_BITS = 11,
  parameter int SYN_W   = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYN_W-1:0] syndrome,
  output logic             rx_shift,
  output logic             dec_capture,
  output logic             tx_load,
  output logic             tx_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done,
  output logic             err_flag
`ifdef HAM_ERR_CNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  localparam int CNT_W = $clog2(CW_BITS + 1);
  localparam logic [CNT_W-1:0] CW_LAST = CNT_W'(CW_BITS - 1);
  localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DW_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    DECODE,
    LOAD,
    SEND
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_flag_q, err_flag_d;
  logic             frame_done_q, frame_done_d;
`ifdef HAM_ERR_CNT_EN
  logic [15:0]      err_count_q, err_count_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_flag_d   = err_flag_q;
    frame_done_d = 1'b0;
`ifdef HAM_ERR_CNT_EN
    err_count_d  = err_count_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RECV;
          cnt_d      = '0;
          err_flag_d = 1'b0;
        end
      end
      RECV: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW_LAST) begin
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        err_flag_d = |syndrome;
`ifdef HAM_ERR_CNT_EN
        // Saturate rather than wrap so a long error burst stays visible.
        if ((|syndrome) && (err_count_q != 16'hFFFF)) begin
          err_count_d = err_count_q + 16'd1;
        end
`endif
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DW_LAST) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      err_flag_q   <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef HAM_ERR_CNT_EN
      err_count_q  <= 16'h0000;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_flag_q   <= err_flag_d;
      frame_done_q <= frame_done_d;
`ifdef HAM_ERR_CNT_EN
      err_count_q  <= err_count_d;
`endif
    end
  end

  // Strobes decode straight from the state flop; only the
  // handshake enables see the live valid/ready inputs.
  assign in_ready    = (state_q == RECV);
  assign rx_shift    = in_ready & in_valid;
  assign dec_capture = (state_q == DECODE);
  assign tx_load     = (state_q == LOAD);
  assign out_valid   = (state_q == SEND);
  assign tx_shift    = out_valid & out_ready;
  assign out_last    = out_valid && (cnt_q == DW_LAST);
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign err_flag    = err_flag_q;
`ifdef HAM_ERR_CNT_EN
  assign err_count   = err_count_q;
`endif

endmodule
